round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/round_controller.sv | 136 +++++++++++++
 tb/tb_round_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Round sequencer for the permutation datapath: walks the stage units in order, then steps the round counter.
// Build option: define ROUND_CTRL_ADD_RC_EN to make AddRC (stage 4) the last stage of each round.
module round_controller #(
   parameter int NUM_STAGES = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NUM_STAGES-1:0] stage_done,
   input  logic                  round_done,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [NUM_STAGES-1:0] stage_count,
   output logic [NUM_STAGES-1:0] stage_write,
   output logic                  inc_step,
   output logic                  clr_step,
   output logic                  ready,
   output logic                  done
);

   localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

`ifdef ROUND_CTRL_ADD_RC_EN
   localparam int LAST_STAGE = NUM_STAGES - 1;
`else
   localparam int LAST_STAGE = NUM_STAGES - 2;
`endif

   localparam logic [KW-1:0] LAST_K = KW'(LAST_STAGE);
   // Stages above LAST_STAGE are never selected, so their one-hot bits stay tied low.
   localparam logic [NUM_STAGES-1:0] STAGE_MASK =
      NUM_STAGES'((64'd1 << (LAST_STAGE + 1)) - 64'd1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      INC,
      CHECK,
      FINISH
   } state_t;

   state_t        state;
   logic [KW-1:0] k;

   function automatic logic [NUM_STAGES-1:0] stage_sel(input logic [KW-1:0] idx);
      stage_sel = STAGE_MASK & (NUM_STAGES'(1) << idx);
   endfunction

   // Every output is registered and decoded from the state being entered, so
   // each pulse lines up exactly with the state that owns it.
   // NOTE: all state and outputs use non-blocking assignments so every read in
   // this block sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         k           <= '0;
         stage_start <= '0;
         stage_count <= '0;
         stage_write <= '0;
         inc_step    <= 1'b0;
         clr_step    <= 1'b0;
         ready       <= 1'b1;
         done        <= 1'b0;
      end else begin
         stage_start <= '0;
         inc_step    <= 1'b0;
         clr_step    <= 1'b0;
         done        <= 1'b0;
         ready       <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  k           <= '0;
                  clr_step    <= 1'b1;
                  stage_start <= stage_sel('0);
                  state       <= START;
               end else begin
                  ready <= 1'b1;
               end
            end

            START: begin
               stage_count <= stage_sel(k);
               stage_write <= stage_sel(k);
               state       <= RUN;
            end

            // Count/write stay high through the cycle in which done is sampled.
            RUN: begin
               if (stage_done[k]) begin
                  stage_count <= '0;
                  stage_write <= '0;
                  if (k == LAST_K) begin
                     inc_step <= 1'b1;
                     state    <= INC;
                  end else begin
                     k           <= k + KW'(1);
                     stage_start <= stage_sel(k + KW'(1));
                     state       <= START;
                  end
               end
            end

            INC: begin
               state <= CHECK;
            end

            CHECK: begin
               if (round_done) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  k           <= '0;
                  stage_start <= stage_sel('0);
                  state       <= START;
               end
            end

            FINISH: begin
               ready <= 1'b1;
               state <= IDLE;
            end

            default: begin
               k           <= '0;
               stage_count <= '0;
               stage_write <= '0;
               ready       <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: stub stage units with programmable latency,
// a step-counter model, and an arithmetic latency model derived from the round rules.
module tb_round_controller;

   localparam int NS = 5;
`ifdef ROUND_CTRL_ADD_RC_EN
   localparam int LAST = 4;
`else
   localparam int LAST = 3;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [NS-1:0] stage_done = '0;
   logic          round_done = 1'b0;
   logic [NS-1:0] stage_start, stage_count, stage_write;
   logic          inc_step, clr_step, ready, done;

   int n_cmp = 0;
   int n_err = 0;

   int cyc = 0;
   int acc_cyc = 0;
   int lat[NS];
   int run_cnt[NS];
   int step_cnt = 0;
   int step_limit = 24;
   bit noise_en = 1'b0;

   int clr_cnt, inc_cnt, sc1_cnt, ss4_cnt, onehot_err, busy_ready, first_ss;

   round_controller #(.NUM_STAGES(NS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stage_done (stage_done),
      .round_done (round_done),
      .stage_start(stage_start),
      .stage_count(stage_count),
      .stage_write(stage_write),
      .inc_step   (inc_step),
      .clr_step   (clr_step),
      .ready      (ready),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic int exp_latency(input int limit);
      int per;
      per = 2;
      for (int s = 0; s <= LAST; s++) per += 1 + lat[s];
      return limit * per + 1;
   endfunction

   task automatic clear_stats();
      clr_cnt = 0; inc_cnt = 0; sc1_cnt = 0; ss4_cnt = 0;
      onehot_err = 0; busy_ready = 0; first_ss = -1;
   endtask

   // Advance one cycle, observe outputs #1 after the edge, then drive this cycle's inputs.
   task automatic tick();
      logic [NS-1:0] sd;
      @(posedge clk);
      #1;
      cyc++;
      if ($countones(stage_start) > 1 || $countones(stage_count) > 1 ||
          $countones(stage_write) > 1 || stage_count !== stage_write)
         onehot_err++;
      if (clr_step) clr_cnt++;
      if (inc_step) inc_cnt++;
      if (stage_count[1]) sc1_cnt++;
      if (stage_start[4]) ss4_cnt++;
      if (stage_start[0] && first_ss < 0) first_ss = cyc;

      round_done = (step_cnt == step_limit);
      if (clr_step) step_cnt = 0;
      else if (inc_step) step_cnt++;

      sd = '0;
      for (int s = 0; s < NS; s++) begin
         if (stage_start[s]) run_cnt[s] = 0;
         if (stage_count[s]) begin
            run_cnt[s]++;
            sd[s] = (run_cnt[s] == lat[s]);
         end else begin
            sd[s] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      stage_done = sd;
   endtask

   // Starts a permutation in the current (IDLE) cycle and returns in the FINISH cycle.
   task automatic run_perm(input int limit, input bit noisy, input bit hold, output int latency);
      bit got;
      step_limit = limit;
      noise_en   = noisy;
      clear_stats();
      start   = 1'b1;
      acc_cyc = cyc;
      got     = 1'b0;
      for (int i = 0; i < 5000 && !got; i++) begin
         tick();
         if (done) got = 1'b1;
         else begin
            if (ready) busy_ready++;
            start = hold ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
         end
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL run_timeout: done not seen within 5000 cycles (limit %0d)", limit);
      end
      latency = cyc - acc_cyc;
      start   = (hold || noisy) ? 1'b1 : 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({stage_start, stage_count, stage_write, inc_step, clr_step, done} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b required 0",
                  {stage_start, stage_count, stage_write, inc_step, clr_step, done});
      end
      n_cmp++;
      if (ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b required 1", ready);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      clear_stats();
      repeat (3) tick();
      n_cmp++;
      if (ready !== 1'b1 || clr_cnt != 0 || stage_start !== '0) begin
         n_err++;
         $display("FAIL idle_hold: ready %b clr %0d stage_start %b required 1/0/0",
                  ready, clr_cnt, stage_start);
      end
   endtask

   task automatic test_full_run();
      int latency;
      for (int s = 0; s < NS; s++) lat[s] = 1;
      run_perm(24, 1'b0, 1'b0, latency);
      n_cmp++;
      if (latency != exp_latency(24)) begin
         n_err++;
         $display("FAIL full_latency: got %0d required %0d", latency, exp_latency(24));
      end
      n_cmp++;
      if (inc_cnt != 24) begin
         n_err++;
         $display("FAIL full_inc_step: got %0d required 24", inc_cnt);
      end
      n_cmp++;
      if (clr_cnt != 1) begin
         n_err++;
         $display("FAIL full_clr_step: got %0d required 1", clr_cnt);
      end
      n_cmp++;
      if (ss4_cnt != ((LAST == 4) ? 24 : 0)) begin
         n_err++;
         $display("FAIL full_stage4_starts: got %0d required %0d", ss4_cnt, (LAST == 4) ? 24 : 0);
      end
      n_cmp++;
      if (onehot_err != 0) begin
         n_err++;
         $display("FAIL full_onehot: got %0d violations required 0", onehot_err);
      end
      n_cmp++;
      if (busy_ready != 0 || first_ss != acc_cyc + 1) begin
         n_err++;
         $display("FAIL full_ready_start: ready-busy %0d first start cyc %0d required 0/%0d",
                  busy_ready, first_ss, acc_cyc + 1);
      end
      tick();
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         n_err++;
         $display("FAIL full_after: done %b ready %b required 0/1", done, ready);
      end
   endtask

   task automatic test_stage1_latency();
      int latency, limit;
      for (int s = 0; s < NS; s++) lat[s] = $urandom_range(1, 3);
      lat[1] = 5;
      limit  = $urandom_range(2, 4);
      run_perm(limit, 1'b0, 1'b0, latency);
      n_cmp++;
      if (sc1_cnt != 5 * limit) begin
         n_err++;
         $display("FAIL stage1_count_cycles: got %0d required %0d", sc1_cnt, 5 * limit);
      end
      n_cmp++;
      if (latency != exp_latency(limit)) begin
         n_err++;
         $display("FAIL stage1_latency: got %0d required %0d", latency, exp_latency(limit));
      end
      tick();
      start = 1'b0;
   endtask

   task automatic test_spurious();
      int latency, limit;
      for (int r = 0; r < 3; r++) begin
         for (int s = 0; s < NS; s++) lat[s] = $urandom_range(1, 4);
         limit = $urandom_range(1, 3);
         run_perm(limit, 1'b1, 1'b0, latency);
         n_cmp++;
         if (latency != exp_latency(limit)) begin
            n_err++;
            $display("FAIL spurious_latency[%0d]: got %0d required %0d", r, latency, exp_latency(limit));
         end
         n_cmp++;
         if (clr_cnt != 1 || inc_cnt != limit || onehot_err != 0) begin
            n_err++;
            $display("FAIL spurious_pulses[%0d]: clr %0d inc %0d onehot %0d required 1/%0d/0",
                     r, clr_cnt, inc_cnt, onehot_err, limit);
         end
         tick();
         start = 1'b0;
         tick();
         n_cmp++;
         if (stage_start !== '0 || clr_step !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL spurious_no_queue[%0d]: stage_start %b clr %b ready %b required 0/0/1",
                     r, stage_start, clr_step, ready);
         end
      end
      noise_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int latency;
      for (int s = 0; s < NS; s++) lat[s] = 1;
      run_perm(2, 1'b0, 1'b1, latency);
      tick();
      n_cmp++;
      if (ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_ready: got %b required 1", ready);
      end
      run_perm(2, 1'b0, 1'b0, latency);
      n_cmp++;
      if (first_ss != acc_cyc + 1 || clr_cnt != 1) begin
         n_err++;
         $display("FAIL b2b_restart: first start cyc %0d clr %0d required %0d/1",
                  first_ss, clr_cnt, acc_cyc + 1);
      end
      n_cmp++;
      if (latency != exp_latency(2)) begin
         n_err++;
         $display("FAIL b2b_latency: got %0d required %0d", latency, exp_latency(2));
      end
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      for (int s = 0; s < NS; s++) lat[s] = 3;
      step_limit = 4;
      start = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         start = 1'b0;
         if (stage_count[2]) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL midrun_reach: stage 2 RUN not reached within 200 cycles");
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({stage_start, stage_count, stage_write, inc_step, clr_step, done} !== '0 || ready !== 1'b1) begin
         n_err++;
         $display("FAIL midrun_reset: outputs %b ready %b required 0/1",
                  {stage_start, stage_count, stage_write, inc_step, clr_step, done}, ready);
      end
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b1;
      clear_stats();
      tick();
      start = 1'b0;
      n_cmp++;
      if (stage_start !== NS'(1) || clr_step !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_accept: stage_start %b clr %b required 00001/1", stage_start, clr_step);
      end
      rst = 1'b0;
      #2 rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_stage1_latency();
      test_spurious();
      test_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
